ps2_key_decoder: RTL and testbench

- Parametrised PS/2 keyboard receiver running entirely in the clock50 domain.
- Synchronises and filters ps2_clk and ps2_dat, then captures 11-bit frames and checks start, parity and stop bits, with a frame timeout.
- Decodes the E0 (extended) and F0 (break) prefixes and tracks held/pressed state for a configurable key table, e.g. W/A/S/D for game control.
- Buffers every decoded code in a ready/valid FIFO for downstream consumers such as the HEX display or game logic.

---
 rtl/ps2_key_decoder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame capture with timeout,
// E0/F0 prefix decode, held/pressed tracking for a key table, and a code FIFO.
module ps2_key_decoder #(
  parameter int                    FILTER_LEN     = 8,
  parameter int                    TIMEOUT_CYCLES = 100000,
  parameter int                    FIFO_DEPTH     = 8,
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h23, 8'h1B, 8'h1C, 8'h1D}
) (
  input  logic                          clock50,
  input  logic                          clear,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic [7:0]                    code_data,
  output logic                          code_break,
  output logic                          code_ext,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [NUM_KEYS-1:0]           key_held,
  output logic [NUM_KEYS-1:0]           key_press,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    dbg_state    // 0 IDLE, 1 RECV, 2 CHECK
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Input conditioning
  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic       filt_clk_q, filt_clk_d;
  logic [7:0] filt_cnt_q, filt_cnt_d;
  logic       sample_evt;
  logic       sample_bit;

  // Frame capture
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          byte_ok;
  logic          frame_good;

  // Decode and key table
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic                emit;
  logic [7:0]          emit_byte;
  logic [NUM_KEYS-1:0] key_held_q, key_held_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;

  // FIFO
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [9:0]    head;

  // Filtered clock flips only once the synchronised clock has disagreed with
  // it for FILTER_LEN consecutive samples; any agreement restarts the count.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
        filt_clk_d = ~filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
    sample_evt = filt_clk_q & ~filt_clk_d;
    sample_bit = dat_sync_q[1];
  end

  // shift_q holds bits 1..10 of the frame: [7:0] data, [8] parity, [9] stop
  assign frame_good = (^shift_q[8:0]) & shift_q[9];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (sample_evt && !sample_bit) begin
          state_d   = ST_RECV;
          bit_cnt_d = 4'd1;
        end
      end
      ST_RECV: begin
        if (sample_evt) begin
          shift_d   = {sample_bit, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d = ST_CHECK;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          timer_d     = '0;
          frame_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CHECK: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        if (frame_good) begin
          byte_ok = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prefix flags survive only across good frames; any error forgets them.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    emit      = 1'b0;
    emit_byte = shift_q[7:0];
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok) begin
      if (emit_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (emit_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        emit  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_comb begin
    key_held_d  = key_held_q;
    key_press_d = '0;
    if (emit && !ext_q) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (emit_byte == KEY_CODES[8*i +: 8]) begin
          if (brk_q) begin
            key_held_d[i] = 1'b0;
          end else begin
            key_held_d[i]  = 1'b1;
            key_press_d[i] = ~key_held_q[i];
          end
        end
      end
    end
  end

  // Handshake: the head entry transfers on any cycle where code_valid and
  // code_ready are both 1; code_valid never drops until that transfer happens.
  // A push into a full FIFO succeeds only if a pop frees a slot that cycle.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && code_ready;
  assign push       = emit && (!fifo_full || pop);

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (emit && fifo_full && !pop);
    if (push) begin
      mem_d[wr_ptr_q] = {emit_byte, brk_q, ext_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock50) begin
    if (clear) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_held_q  <= '0;
      key_press_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_held_q  <= key_held_d;
      key_press_q <= key_press_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign code_valid = !fifo_empty;
  assign code_data  = fifo_empty ? 8'h00 : head[9:2];
  assign code_break = !fifo_empty && head[1];
  assign code_ext   = !fifo_empty && head[0];
  assign key_held   = key_held_q;
  assign key_press  = key_press_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed PS/2 frames, a queue-based reference model
// of decode/FIFO/key state, a per-cycle compare process and literal spot checks.
module tb_ps2_key_decoder;

  localparam int FL     = 8;
  localparam int TO     = 400;
  localparam int DEPTH  = 8;
  localparam int NK     = 4;
  localparam int HP     = 20;
  localparam int LAT_OK = FL + 3;
  localparam int LAT_TO = FL + 2 + TO;

  logic          clock50 = 1'b0;
  logic          clear = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          code_ready = 1'b0;
  logic [7:0]    code_data;
  logic          code_break;
  logic          code_ext;
  logic          code_valid;
  logic [NK-1:0] key_held;
  logic [NK-1:0] key_press;
  logic          frame_err;
  logic          overflow;
  logic [3:0]    fifo_count;
  logic [1:0]    dbg_state;

  ps2_key_decoder #(
    .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .NUM_KEYS(NK),
    .KEY_CODES(32'h231B1C1D)
  ) dut (
    .clock50(clock50), .clear(clear), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .code_data(code_data), .code_break(code_break), .code_ext(code_ext),
    .code_valid(code_valid), .code_ready(code_ready), .key_held(key_held),
    .key_press(key_press), .frame_err(frame_err), .overflow(overflow),
    .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock50 = ~clock50;

  typedef struct {
    int         due;
    logic [7:0] b;
    bit         good;
    bit         is_to;
  } ev_t;

  ev_t           ev_q[$];
  logic [9:0]    exp_q[$];
  logic [7:0]    kc [NK] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
  bit            m_ext, m_brk, m_ovf, m_err;
  logic [NK-1:0] m_held, m_press;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            press0_seen = 0;
  int            err_seen = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // reference model: state as it must look after each rising edge
  initial begin
    ev_t e;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_held = '0; m_press = '0;
    forever begin
      @(posedge clock50);
      cyc++;
      m_press = '0;
      m_err   = 1'b0;
      if (clear) begin
        exp_q.delete();
        ev_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_held = '0;
      end else begin
        if (exp_q.size() != 0 && code_ready) void'(exp_q.pop_front());
        if (ev_q.size() != 0 && ev_q[0].due == cyc) begin
          e = ev_q.pop_front();
          if (e.is_to || !e.good) begin
            m_err = 1'b1; m_ext = 0; m_brk = 0;
          end else if (e.b == 8'hE0) begin
            m_ext = 1'b1;
          end else if (e.b == 8'hF0) begin
            m_brk = 1'b1;
          end else begin
            for (int i = 0; i < NK; i++) begin
              if (!m_ext && e.b == kc[i]) begin
                if (m_brk) m_held[i] = 1'b0;
                else begin
                  if (!m_held[i]) m_press[i] = 1'b1;
                  m_held[i] = 1'b1;
                end
              end
            end
            if (exp_q.size() < DEPTH) exp_q.push_back({e.b, m_brk, m_ext});
            else m_ovf = 1'b1;
            m_ext = 0; m_brk = 0;
          end
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  initial begin
    forever begin
      @(negedge clock50);
      if (chk_en) begin
        chk("valid", code_valid, exp_q.size() != 0);
        chk("count", fifo_count, exp_q.size());
        if (exp_q.size() != 0) begin
          chk("head_data", code_data, exp_q[0][9:2]);
          chk("head_brk", code_break, exp_q[0][1]);
          chk("head_ext", code_ext, exp_q[0][0]);
        end
        chk("key_held", key_held, m_held);
        chk("key_press", key_press, m_press);
        chk("frame_err", frame_err, m_err);
        chk("overflow", overflow, m_ovf);
        if (key_press[0]) press0_seen++;
        if (frame_err) err_seen++;
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clock50);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(2);
    clear = 1'b0;
  endtask

  task automatic drain();
    code_ready = 1'b1;
    idle(DEPTH + 4);
    code_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit rdy_pulse);
    logic [10:0] bits;
    ev_t         e;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      idle(HP);
      ps2_clk = 1'b0;
      if (i == nbits - 1) begin
        e.b     = b;
        e.good  = !bad_par;
        e.is_to = (nbits != 11);
        e.due   = cyc + ((nbits == 11) ? LAT_OK : LAT_TO);
        ev_q.push_back(e);
      end
      if (i == 10 && rdy_pulse) begin
        idle(LAT_OK - 1);
        code_ready = 1'b1;
        idle(1);
        code_ready = 1'b0;
        idle(HP - LAT_OK);
      end else begin
        idle(HP);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  initial begin
    idle(3);
    clear = 1'b0;
    idle(1);
    chk("rst_valid", code_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_held", key_held, 0);
    chk("rst_press", key_press, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", code_data, 0);
    chk("rst_state", dbg_state, 0);
    chk_en = 1'b1;

    // make W
    send(8'h1D);
    idle(HP);
    chk("w_valid", code_valid, 1);
    chk("w_data", code_data, 8'h1D);
    chk("w_held", key_held, 4'b0001);
    chk("w_press_cnt", press0_seen, 1);

    // typematic repeat then break
    send(8'h1D); send(8'h F0); send(8'h1D);
    idle(HP);
    chk("rb_count", fifo_count, 3);
    chk("rb_held", key_held, 4'b0000);
    chk("rb_press_cnt", press0_seen, 1);
    drain();
    chk("rb_empty", fifo_count, 0);

    // extended make and break never touch the table
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
    idle(HP);
    chk("ext_count", fifo_count, 2);
    chk("ext_data", code_data, 8'h1C);
    chk("ext_ext", code_ext, 1);
    chk("ext_brk", code_break, 0);
    chk("ext_held", key_held, 0);
    drain();

    // parity error
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    idle(HP);
    chk("par_count", fifo_count, 0);
    chk("par_err_cnt", err_seen, 1);

    // stalled frame after bit 5
    send_frame(8'h1B, 1'b0, 6, 1'b0);
    idle(TO + 40);
    chk("to_err_cnt", err_seen, 2);
    chk("to_state", dbg_state, 0);

    // recovery
    send(8'h1B);
    idle(HP);
    chk("rec_held", key_held, 4'b0100);
    chk("rec_data", code_data, 8'h1B);
    drain();

    // short clock glitches are filtered out
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      idle(3);
      ps2_clk = 1'b1;
      idle(12);
    end
    chk("gl_state", dbg_state, 0);
    chk("gl_count", fifo_count, 0);
    chk("gl_err_cnt", err_seen, 2);
    send(8'h23);
    idle(HP);
    chk("d_held", key_held, 4'b1100);
    drain();

    // overflow: ninth code lost
    for (int i = 0; i < DEPTH + 1; i++) send(8'(8'h30 + i));
    idle(HP);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", code_data, 8'h30);
    drain();
    chk("ovf_drained", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // push coinciding with pop while full
    do_clear();
    chk("clr_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i));
    send_frame(8'h48, 1'b0, 11, 1'b1);
    idle(HP);
    chk("pp_count", fifo_count, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", code_data, 8'h41);
    drain();

    // clear mid-frame
    send(8'h1D);
    drain();
    send_frame(8'h1C, 1'b0, 4, 1'b0);
    do_clear();
    idle(TO + 40);
    chk("cm_err_cnt", err_seen, 2);
    chk("cm_state", dbg_state, 0);
    chk("cm_held", key_held, 0);
    chk("cm_count", fifo_count, 0);
    chk("cm_valid", code_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
